sobel_window_gen: RTL and testbench

Streaming 3×3 neighbourhood generator that feeds the Sobel gradient stage. It accepts one 8-bit grayscale pixel per valid cycle in raster order and buffers the two previous image rows in line buffers. For every interior pixel it emits the 72-bit window in the packing the gradient modules consume. It sits between the pixel source (camera/BRAM reader) and the horizontal/vertical gradient blocks.

---
 rtl/sobel_pkg.sv | 19 +
 rtl/sobel_line_buf.sv | 25 ++
 rtl/sobel_window_gen.sv | 135 +++++++++++++
 tb/tb_sobel_window_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel pipeline: pixel/window widths and the byte
// offsets of each neighbour inside the packed 3x3 window.
package sobel_pkg;

   localparam int unsigned PIX_W = 8;
   localparam int unsigned WIN_W = 72;

   // Row-major, top-left in the MSB byte
   localparam int unsigned OFF_TL = 64;
   localparam int unsigned OFF_TM = 56;
   localparam int unsigned OFF_TR = 48;
   localparam int unsigned OFF_ML = 40;
   localparam int unsigned OFF_MM = 32;
   localparam int unsigned OFF_MR = 24;
   localparam int unsigned OFF_BL = 16;
   localparam int unsigned OFF_BM = 8;
   localparam int unsigned OFF_BR = 0;

endpackage

// File: rtl/sobel_line_buf.sv
// One image row of pixel storage: asynchronous read, synchronous write.
// Contents are deliberately not reset.
module sobel_line_buf #(
   parameter int unsigned Depth = 64,
   parameter int unsigned Width = 8,
   localparam int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic [Width-1:0] wdata_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel gradient stage.
// Optional SOBEL_WIN_FLAGS_EN adds win_first / win_eol window flags.
module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int unsigned IMG_W = 64,
   parameter int unsigned IMG_H = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic [WIN_W-1:0] win_out,
   output logic             win_valid,
   output logic             frame_done
`ifdef SOBEL_WIN_FLAGS_EN
   ,
   output logic             win_first,
   output logic             win_eol
`endif
);

   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [WIN_W-1:0] sr_q, sr_d;
   logic [WIN_W-1:0] win_out_q, win_out_d;
   logic             win_valid_q, win_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             win_first_q, win_first_d;
   logic             win_eol_q, win_eol_d;

   logic [PIX_W-1:0] lb0_rd, lb1_rd;
   logic             col_last, row_last, emit, lb_we;

   // A pixel arriving with rst is discarded, so it must not touch the buffers
   assign lb_we = pix_valid && !rst;

   sobel_line_buf #(
      .Depth (IMG_W),
      .Width (PIX_W)
   ) u_lb0 (
      .clk     (clk),
      .we_i    (lb_we),
      .addr_i  (col_q),
      .wdata_i (pix_in),
      .rdata_o (lb0_rd)
   );

   sobel_line_buf #(
      .Depth (IMG_W),
      .Width (PIX_W)
   ) u_lb1 (
      .clk     (clk),
      .we_i    (lb_we),
      .addr_i  (col_q),
      .wdata_i (lb0_rd),
      .rdata_o (lb1_rd)
   );

   assign col_last = (col_q == COL_W'(IMG_W - 1));
   assign row_last = (row_q == ROW_W'(IMG_H - 1));
   assign emit     = pix_valid && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      sr_d         = sr_q;
      win_out_d    = win_out_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      win_first_d  = 1'b0;
      win_eol_d    = 1'b0;
      if (pix_valid) begin
         col_d = col_last ? '0 : col_q + COL_W'(1);
         if (col_last) begin
            row_d = row_last ? '0 : row_q + ROW_W'(1);
         end
         // Shift columns left; the new right column comes from the line buffers
         sr_d[OFF_TL +: PIX_W] = sr_q[OFF_TM +: PIX_W];
         sr_d[OFF_TM +: PIX_W] = sr_q[OFF_TR +: PIX_W];
         sr_d[OFF_TR +: PIX_W] = lb1_rd;
         sr_d[OFF_ML +: PIX_W] = sr_q[OFF_MM +: PIX_W];
         sr_d[OFF_MM +: PIX_W] = sr_q[OFF_MR +: PIX_W];
         sr_d[OFF_MR +: PIX_W] = lb0_rd;
         sr_d[OFF_BL +: PIX_W] = sr_q[OFF_BM +: PIX_W];
         sr_d[OFF_BM +: PIX_W] = sr_q[OFF_BR +: PIX_W];
         sr_d[OFF_BR +: PIX_W] = pix_in;
         frame_done_d = col_last && row_last;
      end
      if (emit) begin
         win_out_d   = sr_d;
         win_valid_d = 1'b1;
         win_first_d = (row_q == ROW_W'(2)) && (col_q == COL_W'(2));
         win_eol_d   = col_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         sr_q         <= '0;
         win_out_q    <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_first_q  <= 1'b0;
         win_eol_q    <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         sr_q         <= sr_d;
         win_out_q    <= win_out_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         win_first_q  <= win_first_d;
         win_eol_q    <= win_eol_d;
      end
   end

   assign win_out    = win_out_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

`ifdef SOBEL_WIN_FLAGS_EN
   assign win_first = win_first_q;
   assign win_eol   = win_eol_q;
`else
   logic unused_flags;
   assign unused_flags = win_first_q ^ win_eol_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: a 4x4 instance for the main cases and
// a 5x3 instance for the flat-field case.
module tb_sobel_window_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [7:0]  pix4 = '0;
   logic        val4 = 1'b0;
   logic [71:0] win4;
   logic        wv4, fd4;
   logic        first4, eol4;

   logic [7:0]  pix53 = '0;
   logic        val53 = 1'b0;
   logic [71:0] win53;
   logic        wv53, fd53;
   logic        first53, eol53;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [71:0] win;
      logic        wv;
      logic        fd;
      logic        first;
      logic        eol;
   } ev_t;

   ev_t q4[$];
   ev_t q53[$];
   ev_t tbl[4];

   logic pv4_q  = 1'b0;
   logic pv53_q = 1'b0;

   always #5 clk = ~clk;

   sobel_window_gen #(.IMG_W(4), .IMG_H(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix4),
      .pix_valid  (val4),
      .win_out    (win4),
      .win_valid  (wv4),
      .frame_done (fd4)
`ifdef SOBEL_WIN_FLAGS_EN
      ,
      .win_first  (first4),
      .win_eol    (eol4)
`endif
   );

   sobel_window_gen #(.IMG_W(5), .IMG_H(3)) dut53 (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix53),
      .pix_valid  (val53),
      .win_out    (win53),
      .win_valid  (wv53),
      .frame_done (fd53)
`ifdef SOBEL_WIN_FLAGS_EN
      ,
      .win_first  (first53),
      .win_eol    (eol53)
`endif
   );

`ifndef SOBEL_WIN_FLAGS_EN
   assign first4  = 1'b0;
   assign eol4    = 1'b0;
   assign first53 = 1'b0;
   assign eol53   = 1'b0;
`endif

   task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   always @(posedge clk) begin
      pv4_q  <= val4 && !rst;
      pv53_q <= val53 && !rst;
   end

   // Collect every output event; outputs after an idle cycle must be quiet
   always @(negedge clk) begin
      ev_t e;
      if (wv4 || fd4) begin
         e.win = win4; e.wv = wv4; e.fd = fd4; e.first = first4; e.eol = eol4;
         q4.push_back(e);
      end
      if (wv53 || fd53) begin
         e.win = win53; e.wv = wv53; e.fd = fd53; e.first = first53; e.eol = eol53;
         q53.push_back(e);
      end
      if (!pv4_q && !rst) begin
         chk("idle_win_valid4", {71'd0, wv4}, 72'd0);
         chk("idle_frame_done4", {71'd0, fd4}, 72'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pixels4(input int npix, input int gap_max, input logic [7:0] ofs);
      for (int i = 0; i < npix; i++) begin
         int gaps;
         gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         repeat (gaps) begin
            val4 = 1'b0;
            tick();
         end
         pix4 = 8'(16 * (i / 4) + (i % 4)) | ofs;
         val4 = 1'b1;
         tick();
      end
      val4 = 1'b0;
   endtask

   task automatic verify4(input string tag, input int nframes);
      int n;
      chk({tag, "_count"}, 72'(q4.size()), 72'(4 * nframes));
      n = (q4.size() < 4 * nframes) ? q4.size() : 4 * nframes;
      for (int i = 0; i < n; i++) begin
         logic [7:0] xb;
         ev_t e;
         e  = tbl[i % 4];
         xb = (i >= 4) ? 8'h80 : 8'h00;
         chk($sformatf("%s_win%0d", tag, i), q4[i].win, e.win ^ {9{xb}});
         chk($sformatf("%s_wv%0d", tag, i), {71'd0, q4[i].wv}, 72'd1);
         chk($sformatf("%s_fd%0d", tag, i), {71'd0, q4[i].fd}, {71'd0, e.fd});
`ifdef SOBEL_WIN_FLAGS_EN
         chk($sformatf("%s_first%0d", tag, i), {71'd0, q4[i].first}, {71'd0, e.first});
         chk($sformatf("%s_eol%0d", tag, i), {71'd0, q4[i].eol}, {71'd0, e.eol});
`endif
      end
      q4.delete();
   endtask

   initial begin
      tbl[0] = '{72'h000102_101112_202122, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{72'h010203_111213_212223, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{72'h101112_202122_303132, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{72'h111213_212223_313233, 1'b1, 1'b1, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_win_out", win4, 72'd0);
      chk("rst_win_valid", {71'd0, wv4}, 72'd0);
      chk("rst_frame_done", {71'd0, fd4}, 72'd0);
      chk("rst_win_out53", win53, 72'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Continuous 4x4 frame
      send_pixels4(16, 0, 8'h00);
      repeat (3) tick();
      verify4("cont", 1);

      // Same frame with random idle gaps
      send_pixels4(16, 3, 8'h00);
      repeat (3) tick();
      verify4("gaps", 1);

      // Reset after pixel (2,1); the pixel sent alongside rst is dropped
      send_pixels4(10, 1, 8'h00);
      rst  = 1'b1;
      pix4 = 8'h22;
      val4 = 1'b1;
      tick();
      rst  = 1'b0;
      val4 = 1'b0;
      tick();
      chk("rst_mid_no_windows", 72'(q4.size()), 72'd0);
      q4.delete();
      send_pixels4(16, 0, 8'h00);
      repeat (3) tick();
      verify4("after_rst", 1);

      // Back-to-back frames, second frame tagged with bit 7
      send_pixels4(16, 0, 8'h00);
      send_pixels4(16, 0, 8'h80);
      repeat (3) tick();
      verify4("b2b", 2);

      // 5x3 flat field
      for (int i = 0; i < 15; i++) begin
         pix53 = 8'hFF;
         val53 = 1'b1;
         tick();
      end
      val53 = 1'b0;
      repeat (3) tick();
      chk("flat_count", 72'(q53.size()), 72'd3);
      for (int i = 0; i < q53.size() && i < 3; i++) begin
         int gy;
         logic [71:0] w;
         w  = q53[i].win;
         gy = (int'(w[16 +: 8]) + 2 * int'(w[8 +: 8]) + int'(w[0 +: 8]))
            - (int'(w[64 +: 8]) + 2 * int'(w[56 +: 8]) + int'(w[48 +: 8]));
         chk($sformatf("flat_win%0d", i), w, {72{1'b1}});
         chk($sformatf("flat_gy%0d", i), 72'(gy), 72'd0);
         chk($sformatf("flat_fd%0d", i), {71'd0, q53[i].fd}, (i == 2) ? 72'd1 : 72'd0);
`ifdef SOBEL_WIN_FLAGS_EN
         chk($sformatf("flat_first%0d", i), {71'd0, q53[i].first}, (i == 0) ? 72'd1 : 72'd0);
         chk($sformatf("flat_eol%0d", i), {71'd0, q53[i].eol}, (i == 2) ? 72'd1 : 72'd0);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
